// File: rtl/etroc2_sw_pkg.sv
// etroc2_sw_pkg: shared definitions for the SW column readout master.
// Holds the chain word width, bcst bit map, output word type codes and FSM states.
package etroc2_sw_pkg;
    localparam int DATA_W = 39;
    localparam int BCST_LOAD = 11;
    localparam int BCST_L1A = 10;
    localparam int BCST_RST = 9;
    localparam int BCST_DLY_MSB = 8;
    localparam logic [1:0] TYPE_HDR = 2'b01;
    localparam logic [1:0] TYPE_HIT = 2'b10;
    localparam logic [1:0] TYPE_TRL = 2'b11;
    typedef enum logic [2:0] {IDLE, LOAD, HDR, SETTLE, READ, CAP, HOLD, TRL} state_t;
endpackage

// File: rtl/sw_l1_pending_counter.sv
// sw_l1_pending_counter: tracks L1 triggers not yet loaded into the chain.
// Rejects L1As while full and keeps a saturating count of the rejected ones.
module sw_l1_pending_counter #(
    parameter int L1_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       l1a,
    input  logic                       load,
    input  logic                       clear,
    output logic [$clog2(L1_DEPTH):0]  pending,
    output logic                       full,
    output logic                       accept,
    output logic [7:0]                 overflow
);
    localparam int PW = $clog2(L1_DEPTH) + 1;

    assign full = pending == PW'(L1_DEPTH);
    assign accept = l1a & ~full;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pending <= '0;
            overflow <= '0;
        end else begin
            pending <= clear ? '0 : pending + PW'(accept) - PW'(load);
            if (l1a && full && overflow != 8'hff) overflow <= overflow + 8'd1;
        end
endmodule

// File: rtl/sw_column_readout_master.sv
// sw_column_readout_master: drives the SW chain broadcast bus and drains hits as header/hit/trailer words.
// Define SW_READ_TIMEOUT_EN to add a READ-phase watchdog that closes the event and resets the chain.
module sw_column_readout_master #(
    parameter int DATA_W = etroc2_sw_pkg::DATA_W,
    parameter int L1_DEPTH = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              L1A,
    input  logic              swReset,
    input  logic [8:0]        L1ADelay,
    output logic [11:0]       bcst,
    input  logic [DATA_W-1:0] chainData,
    input  logic              chainUnreadHit,
    output logic              chainRead,
    output logic [DATA_W+1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic [7:0]        l1Overflow,
    output logic              busy
);
    import etroc2_sw_pkg::*;

    state_t state;
    logic [$clog2(L1_DEPTH):0] pending;
    logic full, accept, drop, xfer, wd_fire;
    logic [3:0] settle_cnt;
    logic [11:0] event_num;
    logic [7:0] hit_cnt;
    logic ovf_seen, tflag;
    logic bcst_load, bcst_l1a, bcst_rst;
    logic [8:0] bcst_dly;
    logic [DATA_W+1:0] trl_word;

    assign bcst = {bcst_load, bcst_l1a, bcst_rst, bcst_dly};
    assign busy = state != IDLE;
    assign drop = L1A & full;
    assign xfer = outValid & outReady;
    assign trl_word = {TYPE_TRL, {(DATA_W-17){1'b0}}, tflag | wd_fire, ovf_seen | drop, hit_cnt, event_num[6:0]};

    sw_l1_pending_counter #(.L1_DEPTH(L1_DEPTH)) u_pending (
        .clk(clk),
        .reset(reset),
        .l1a(L1A),
        .load(state == LOAD),
        .clear(swReset),
        .pending(pending),
        .full(full),
        .accept(accept),
        .overflow(l1Overflow)
    );

`ifdef SW_READ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;
    logic in_read;
    assign in_read = state == READ || state == CAP || state == HOLD;
    assign wd_fire = in_read && outReady && wd == WDW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) wd <= '0;
        else wd <= (!in_read || swReset || wd_fire) ? '0 : wd + WDW'(outReady);
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            bcst_load <= 1'b0;
            bcst_l1a <= 1'b0;
            bcst_rst <= 1'b1;
            bcst_dly <= '0;
            chainRead <= 1'b0;
            outValid <= 1'b0;
            outData <= '0;
            event_num <= '0;
            hit_cnt <= '0;
            settle_cnt <= '0;
            ovf_seen <= 1'b0;
            tflag <= 1'b0;
        end else begin
            bcst_l1a <= accept;
            bcst_rst <= swReset | wd_fire;
            bcst_dly <= L1ADelay;
            bcst_load <= 1'b0;
            chainRead <= 1'b0;
            ovf_seen <= drop | (ovf_seen & ~(state == TRL && xfer));
            if (swReset) begin
                state <= IDLE;
                outValid <= 1'b0;
                event_num <= '0;
                hit_cnt <= '0;
                tflag <= 1'b0;
            end else if (wd_fire) begin
                state <= TRL;
                tflag <= 1'b1;
                outValid <= 1'b1;
                outData <= trl_word;
            end else
                case (state)
                    IDLE: if (pending != '0) begin
                        state <= LOAD;
                        bcst_load <= 1'b1;
                    end
                    LOAD: begin
                        state <= HDR;
                        outValid <= 1'b1;
                        outData <= {TYPE_HDR, {(DATA_W-12){1'b0}}, event_num};
                    end
                    HDR: if (outReady) begin
                        state <= SETTLE;
                        outValid <= 1'b0;
                        settle_cnt <= '0;
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt + 4'd1;
                        if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state <= READ;
                    end
                    READ: if (chainUnreadHit) begin
                        state <= CAP;
                        chainRead <= 1'b1;
                    end else begin
                        state <= TRL;
                        outValid <= 1'b1;
                        outData <= trl_word;
                    end
                    // chainRead is high during CAP, so chainData here is still the word being popped
                    CAP: begin
                        state <= HOLD;
                        outValid <= 1'b1;
                        outData <= {TYPE_HIT, chainData};
                        hit_cnt <= hit_cnt + {7'd0, hit_cnt != 8'hff};
                    end
                    HOLD: if (outReady) begin
                        state <= READ;
                        outValid <= 1'b0;
                    end
                    TRL: if (outReady) begin
                        state <= IDLE;
                        outValid <= 1'b0;
                        event_num <= event_num + 12'd1;
                        hit_cnt <= '0;
                        tflag <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
        end
endmodule

// File: tb/tb_sw_column_readout_master.sv
// tb_sw_column_readout_master: directed bench with a FIFO model of the SW chain.
// Expected words are built from the header/hit/trailer formats with hand-picked values.
module tb_sw_column_readout_master;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic L1A = 1'b0;
    logic swReset = 1'b0;
    logic outReady = 1'b1;
    logic [8:0] L1ADelay = '0;
    logic [11:0] bcst;
    logic [38:0] chainData;
    logic chainUnreadHit, chainRead, outValid, busy;
    logic [40:0] outData;
    logic [7:0] l1Overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sw_column_readout_master #(.TIMEOUT(20)) dut (
        .clk(clk),
        .reset(reset),
        .L1A(L1A),
        .swReset(swReset),
        .L1ADelay(L1ADelay),
        .bcst(bcst),
        .chainData(chainData),
        .chainUnreadHit(chainUnreadHit),
        .chainRead(chainRead),
        .outData(outData),
        .outValid(outValid),
        .outReady(outReady),
        .l1Overflow(l1Overflow),
        .busy(busy)
    );

    // chain model: hits written by the stimulus, popped by chainRead
    logic [38:0] mem [0:15];
    int head = 0;
    int tail = 0;
    bit stuck = 1'b0;
    assign chainUnreadHit = stuck || head < tail;
    assign chainData = mem[head[3:0]];
    always @(posedge clk) if (chainRead) head <= head + 1;

    logic [40:0] words[$];
    int rd_cnt = 0, ld_cnt = 0, l1a_cnt = 0, rst_cnt = 0;
    always @(posedge clk) begin
        if (outValid && outReady) words.push_back(outData);
        if (chainRead) rd_cnt <= rd_cnt + 1;
        if (bcst[11]) ld_cnt <= ld_cnt + 1;
        if (bcst[10]) l1a_cnt <= l1a_cnt + 1;
        if (bcst[9]) rst_cnt <= rst_cnt + 1;
    end

    function automatic logic [40:0] hdr(int ev);
        return {2'b01, 27'd0, 12'(ev)};
    endfunction
    function automatic logic [40:0] trl(bit tf, bit ov, int hc, int ev);
        return {2'b11, 22'd0, tf, ov, 8'(hc), 7'(ev)};
    endfunction
    function automatic logic [38:0] hitw(int pix, int tdc);
        return {29'(tdc), 2'b01, 8'(pix)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_hit(input int pix, input int tdc);
        mem[tail[3:0]] = hitw(pix, tdc);
        tail++;
    endtask

    task automatic pulse_l1a();
        L1A = 1'b1;
        @(negedge clk);
        L1A = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int k = 0; k < 400 && words.size() < n; k++) @(negedge clk);
        chk("wait_words", 64'(words.size() >= n), 64'd1);
    endtask

    task automatic wait_hit();
        for (int k = 0; k < 100 && !(outValid && outData[40:39] == 2'b10); k++) @(negedge clk);
        chk("wait_hit", 64'(outValid && outData[40:39] == 2'b10), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nw, b_rd, b_ld, b_l1a, b_rst;
        logic [40:0] d_exp;
        L1ADelay = 9'd100;
        cyc(3);
        chk("rst_bcst", bcst, 12'h200);
        chk("rst_chainRead", chainRead, 0);
        chk("rst_outValid", outValid, 0);
        chk("rst_outData", outData, 0);
        chk("rst_l1Overflow", l1Overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", dut.pending, 0);
        reset = 1'b1;
        cyc(2);
        chk("bcst_idle", bcst, {3'b000, 9'd100});

        // single event with three hits
        nw = words.size(); b_rd = rd_cnt; b_ld = ld_cnt; b_l1a = l1a_cnt;
        add_hit(8'h07, 100); add_hit(8'h05, 200); add_hit(8'h02, 300);
        pulse_l1a();
        wait_words(nw + 5);
        cyc(1);
        chk("ev0_hdr", words[nw], hdr(0));
        chk("ev0_hit0", words[nw+1], {2'b10, hitw(8'h07, 100)});
        chk("ev0_hit1", words[nw+2], {2'b10, hitw(8'h05, 200)});
        chk("ev0_hit2", words[nw+3], {2'b10, hitw(8'h02, 300)});
        chk("ev0_trl", words[nw+4], trl(0, 0, 3, 0));
        chk("ev0_reads", rd_cnt - b_rd, 3);
        chk("ev0_loads", ld_cnt - b_ld, 1);
        chk("ev0_l1a_fwd", l1a_cnt - b_l1a, 1);
        chk("ev0_busy", busy, 0);

        // consumer stall for ten cycles on a hit word
        nw = words.size();
        add_hit(8'h09, 'h1234); add_hit(8'h0a, 'h55);
        pulse_l1a();
        wait_hit();
        outReady = 1'b0;
        d_exp = {2'b10, hitw(8'h09, 'h1234)};
        b_rd = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_data", outData, d_exp);
            chk("stall_valid", outValid, 1);
        end
        chk("stall_no_read", rd_cnt - b_rd, 0);
        outReady = 1'b1;
        wait_words(nw + 4);
        cyc(1);
        chk("ev1_hdr", words[nw], hdr(1));
        chk("ev1_hit0", words[nw+1], d_exp);
        chk("ev1_hit1", words[nw+2], {2'b10, hitw(8'h0a, 'h55)});
        chk("ev1_trl", words[nw+3], trl(0, 0, 2, 1));

        // stalled event, then nine L1As: eight fill the counter, the ninth is dropped
        cyc(2);
        nw = words.size();
        outReady = 1'b0;
        pulse_l1a();
        cyc(4);
        b_l1a = l1a_cnt;
        L1A = 1'b1;
        cyc(9);
        L1A = 1'b0;
        cyc(2);
        chk("burst_fwd", l1a_cnt - b_l1a, 8);
        chk("burst_overflow", l1Overflow, 1);
        chk("burst_pending", dut.pending, 8);
        outReady = 1'b1;
        wait_words(nw + 18);
        cyc(1);
        chk("ev2_hdr", words[nw], hdr(2));
        chk("ev2_trl_ovf", words[nw+1], trl(0, 1, 0, 2));
        chk("ev3_trl", words[nw+3], trl(0, 0, 0, 3));
        chk("ev10_hdr", words[nw+16], hdr(10));
        chk("ev10_trl", words[nw+17], trl(0, 0, 0, 10));
        chk("drain_pending", dut.pending, 0);
        chk("drain_busy", busy, 0);

        // L1A in the same cycle as a load keeps pending at 2
        outReady = 1'b0;
        L1A = 1'b1;
        cyc(2);
        chk("same_pending_pre", dut.pending, 2);
        chk("same_load", bcst[11], 1);
        cyc(1);
        L1A = 1'b0;
        chk("same_pending_post", dut.pending, 2);
        swReset = 1'b1;
        cyc(1);
        swReset = 1'b0;
        chk("flush1_bcst_rst", bcst[9], 1);
        chk("flush1_busy", busy, 0);
        chk("flush1_valid", outValid, 0);
        chk("flush1_pending", dut.pending, 0);

        // swReset while a hit word is held
        cyc(2);
        nw = words.size();
        outReady = 1'b1;
        add_hit(8'h03, 77);
        pulse_l1a();
        wait_hit();
        outReady = 1'b0;
        cyc(1);
        swReset = 1'b1;
        cyc(1);
        swReset = 1'b0;
        chk("flush2_bcst_rst", bcst[9], 1);
        chk("flush2_busy", busy, 0);
        chk("flush2_valid", outValid, 0);
        chk("flush2_pending", dut.pending, 0);
        outReady = 1'b1;
        cyc(20);
        chk("flush2_no_trl", words.size(), nw + 1);
        chk("flush2_hdr", words[nw], hdr(0));
        pulse_l1a();
        wait_words(nw + 3);
        cyc(1);
        chk("post_flush_hdr", words[nw+1], hdr(0));
        chk("post_flush_trl", words[nw+2], trl(0, 0, 0, 0));

`ifdef SW_READ_TIMEOUT_EN
        // chain stuck with unread hits: the watchdog closes the event
        cyc(2);
        nw = words.size();
        b_rst = rst_cnt;
        stuck = 1'b1;
        pulse_l1a();
        for (int k = 0; k < 300 && !(words.size() > nw && words[$][40:39] == 2'b11); k++) @(negedge clk);
        stuck = 1'b0;
        cyc(3);
        chk("to_type", words[$][40:39], 2'b11);
        chk("to_flag", words[$][16], 1);
        chk("to_event", words[$][6:0], 1);
        chk("to_rst_pulse", rst_cnt - b_rst, 1);
`else
        b_rst = rst_cnt;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
